// File: rtl/load_port_arbiter_pkg.sv
// Shared constants and width helpers for the load port arbiter slice.
// Used by the round-robin arbiter and the top level.
package load_port_arbiter_pkg;

  localparam int LOAD_LAT_MAX   = 9;
  localparam int NUM_REQ_MIN    = 2;
  localparam int NUM_REQ_MAX    = 16;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int flat_width(input int count, input int width);
    return count * width;
  endfunction

endpackage

// File: rtl/load_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search begins at rr_ptr and wraps
// modulo NumReq, and the first requester it finds wins.
module rr_arbiter
  import load_port_arbiter_pkg::*;
#(
  parameter int  NumReq = DEF_NUM_REQ,
  localparam int IdxW   = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   rr_ptr,
  output logic [NumReq-1:0] gnt,
  output logic [IdxW-1:0]   gnt_idx,
  output logic              any_gnt
);

  int              sum;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    sum     = 0;
    cand    = '0;
    for (int off = 0; off < NumReq; off++) begin
      sum = int'(rr_ptr) + off;
      if (sum >= NumReq) sum = sum - NumReq;
      cand = IdxW'(sum);
      if (!any_gnt && req[cand]) begin
        any_gnt   = 1'b1;
        gnt_idx   = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/load_port_arbiter.sv
// Shares one fixed-latency memory read port between NumReq load operators.
// A tag pipeline tracks in-flight reads and steers the returned data to the owning requester.
module load_port_arbiter
  import load_port_arbiter_pkg::*;
#(
  parameter int NumReq      = DEF_NUM_REQ,
  parameter int AddrWidth   = DEF_ADDR_WIDTH,
  parameter int DataWidth   = DEF_DATA_WIDTH,
  parameter int LoadLatency = 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NumReq-1:0]                        req,
  input  logic [flat_width(NumReq, AddrWidth)-1:0] req_addr,
  output logic [NumReq-1:0]                        gnt,
  output logic                                     mem_rd,
  output logic [AddrWidth-1:0]                     mem_addr,
  input  logic [DataWidth-1:0]                     mem_rdata,
  output logic [NumReq-1:0]                        rvalid,
  output logic [flat_width(NumReq, DataWidth)-1:0] ret
);

  localparam int IdxW   = idx_width(NumReq);
  localparam int Stages = LoadLatency + 1;
  localparam int Last   = Stages - 1;

  if (LoadLatency < 1 || LoadLatency > LOAD_LAT_MAX) begin : g_lat_check
    $error("load_port_arbiter: LoadLatency out of range");
  end
  if (NumReq < NUM_REQ_MIN || NumReq > NUM_REQ_MAX) begin : g_req_check
    $error("load_port_arbiter: NumReq out of range");
  end

  logic [IdxW-1:0]      rr_ptr;
  logic [IdxW-1:0]      gnt_idx;
  logic                 any_gnt;
  logic                 tag_v   [Stages];
  logic [IdxW-1:0]      tag_idx [Stages];
  logic [DataWidth-1:0] held    [NumReq];

  rr_arbiter #(.NumReq(NumReq)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .any_gnt(any_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
    end else begin
      mem_rd <= any_gnt;
      if (any_gnt) begin
        rr_ptr   <= (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
        mem_addr <= req_addr[gnt_idx*AddrWidth +: AddrWidth];
      end
    end
  end

  // Stage 0 is captured on the same edge as mem_rd; the final stage lines up with mem_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < Stages; s++) begin
        tag_v[s]   <= 1'b0;
        tag_idx[s] <= '0;
      end
    end else begin
      tag_v[0]   <= any_gnt;
      tag_idx[0] <= gnt_idx;
      for (int s = 1; s < Stages; s++) begin
        tag_v[s]   <= tag_v[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumReq; i++) held[i] <= '0;
    end else if (tag_v[Last]) begin
      held[tag_idx[Last]] <= mem_rdata;
    end
  end

  always_comb begin
    rvalid = '0;
    ret    = '0;
    for (int i = 0; i < NumReq; i++) ret[i*DataWidth +: DataWidth] = held[i];
    if (tag_v[Last]) begin
      rvalid[tag_idx[Last]]                    = 1'b1;
      ret[tag_idx[Last]*DataWidth +: DataWidth] = mem_rdata;
    end
  end

endmodule

// File: tb/tb_load_port_arbiter.sv
// Randomized and directed scoreboard bench for load_port_arbiter with a behavioural
// memory model and a reference model of round-robin grants and returns.
module tb_load_port_arbiter;

  localparam int NR  = 4;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int LAT = 3;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    int            due;
  } ret_t;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } cmd_t;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    gnt;
  logic             mem_rd;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_rdata;
  logic [NR-1:0]    rvalid;
  logic [NR*DW-1:0] ret;

  ret_t          retq[$];
  cmd_t          cmdq[$];
  logic [NR-1:0] gntq[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            model_ptr = 0;
  logic [DW-1:0] held_model [NR];
  logic [AW-1:0] last_addr;

  logic          memv [LAT];
  logic [AW-1:0] mema [LAT];
  logic [DW-1:0] junk;

  load_port_arbiter #(
    .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .LoadLatency(LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_addr (req_addr),
    .gnt      (gnt),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .rvalid   (rvalid),
    .ret      (ret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] memfunc(input logic [AW-1:0] a);
    return {a ^ 16'hC3A5, a + 16'h0100};
  endfunction

  function automatic logic [NR*AW-1:0] packAddr(input logic [AW-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  // Fixed-latency memory: it keeps returning data even across a DUT reset.
  initial begin
    for (int s = 0; s < LAT; s++) begin
      memv[s] = 1'b0;
      mema[s] = '0;
    end
    junk = '0;
  end

  always @(posedge clk) begin
    memv[0] <= mem_rd;
    mema[0] <= mem_addr;
    for (int s = 1; s < LAT; s++) begin
      memv[s] <= memv[s-1];
      mema[s] <= mema[s-1];
    end
    junk <= $urandom;
  end

  assign mem_rdata = memv[LAT-1] ? memfunc(mema[LAT-1]) : junk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Drives one cycle of requests and records what the reference model expects from it.
  task automatic applyStimulus(input logic [NR-1:0] r, input logic [NR*AW-1:0] a, output int winner);
    logic [NR-1:0] g;
    ret_t          e;
    cmd_t          c;
    int            k;
    @(posedge clk);
    #1;
    req      = r;
    req_addr = a;
    winner   = -1;
    for (int off = 0; off < NR; off++) begin
      k = (model_ptr + off) % NR;
      if (winner < 0 && r[k]) winner = k;
    end
    g = '0;
    if (winner >= 0) begin
      g[winner] = 1'b1;
      c.addr = a[winner*AW +: AW];
      c.due  = cyc + 1;
      cmdq.push_back(c);
      e.idx  = winner;
      e.data = memfunc(a[winner*AW +: AW]);
      e.due  = cyc + 1 + LAT;
      retq.push_back(e);
      model_ptr = (winner + 1) % NR;
    end
    gntq.push_back(g);
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req       = '0;
    model_ptr = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idleCycles(input int n);
    int w;
    for (int i = 0; i < n; i++) applyStimulus('0, req_addr, w);
  endtask

  // Monitor: pops expectations and compares against whatever the DUT presents each cycle.
  always @(negedge clk) begin : monitor
    logic [NR-1:0]    exp_rv;
    logic [NR*DW-1:0] exp_ret;
    logic             exp_rd;
    logic [AW-1:0]    exp_addr;
    ret_t             e;
    if (!rst_n) begin
      retq.delete();
      cmdq.delete();
      gntq.delete();
      for (int i = 0; i < NR; i++) held_model[i] = '0;
      last_addr = '0;
      checkOutput("reset_rvalid", rvalid, '0);
      checkOutput("reset_ret", ret, '0);
      checkOutput("reset_mem_rd", mem_rd, '0);
      checkOutput("reset_mem_addr", mem_addr, '0);
    end else begin
      if (gntq.size() > 0) checkOutput("gnt", gnt, gntq.pop_front());
      exp_rd   = 1'b0;
      exp_addr = last_addr;
      if (cmdq.size() > 0 && cmdq[0].due == cyc) begin
        exp_rd    = 1'b1;
        exp_addr  = cmdq[0].addr;
        last_addr = exp_addr;
        void'(cmdq.pop_front());
      end
      checkOutput("mem_rd", mem_rd, exp_rd);
      checkOutput("mem_addr", mem_addr, exp_addr);
      exp_rv = '0;
      for (int i = 0; i < NR; i++) exp_ret[i*DW +: DW] = held_model[i];
      if (retq.size() > 0 && retq[0].due == cyc) begin
        e = retq.pop_front();
        exp_rv[e.idx]          = 1'b1;
        exp_ret[e.idx*DW +: DW] = e.data;
        held_model[e.idx]      = e.data;
      end
      checkOutput("rvalid", rvalid, exp_rv);
      checkOutput("ret", ret, exp_ret);
    end
  end

  initial begin : stimulus
    logic [NR-1:0]    pend;
    logic [NR*AW-1:0] addrs;
    int               w;
    for (int i = 0; i < NR; i++) held_model[i] = '0;
    last_addr = '0;
    rst_n     = 1'b0;
    req       = '0;
    req_addr  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request from requester 2.
    applyStimulus(4'b0100, packAddr(16'h0, 16'h0, 16'h0010, 16'h0), w);
    idleCycles(LAT + 3);

    // All four requesting from a fresh reset: grants 0,1,2,3,0,1,2,3.
    applyReset();
    for (int c = 0; c < 8; c++)
      applyStimulus(4'b1111, packAddr(AW'(16'h0100 + c), AW'(16'h0200 + c),
                                      AW'(16'h0300 + c), AW'(16'h0400 + c)), w);
    idleCycles(LAT + 2);

    // Requester 1 granted back-to-back with several reads in flight.
    applyStimulus(4'b0010, packAddr(16'h0, 16'h0001, 16'h0, 16'h0), w);
    applyStimulus(4'b0010, packAddr(16'h0, 16'h0002, 16'h0, 16'h0), w);
    applyStimulus(4'b0010, packAddr(16'h0, 16'h0003, 16'h0, 16'h0), w);
    idleCycles(LAT + 3);

    // Fairness: after requester 0 wins, 0 and 3 alternate starting with 3.
    applyStimulus(4'b0001, packAddr(16'h0A00, 16'h0, 16'h0, 16'h0), w);
    for (int c = 0; c < 4; c++)
      applyStimulus(4'b1001, packAddr(AW'(16'h0A10 + c), 16'h0, 16'h0, AW'(16'h0B10 + c)), w);
    idleCycles(LAT + 2);

    // Reset with two reads in flight; nothing may return for them and the pointer restarts.
    applyStimulus(4'b0100, packAddr(16'h0, 16'h0, 16'h0C01, 16'h0), w);
    applyStimulus(4'b1000, packAddr(16'h0, 16'h0, 16'h0, 16'h0C02), w);
    applyReset();
    idleCycles(LAT + 3);
    applyStimulus(4'b1111, packAddr(16'h0D00, 16'h0D01, 16'h0D02, 16'h0D03), w);
    idleCycles(LAT + 2);

    // Idle stretch: mem_addr and held results must not move.
    idleCycles(10);

    // Randomized traffic with holds, drops and one reset in the middle.
    pend  = '0;
    addrs = '0;
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        applyReset();
        pend = '0;
      end
      for (int i = 0; i < NR; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[i]            = 1'b1;
            addrs[i*AW +: AW] = AW'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
      end
      applyStimulus(pend, addrs, w);
      if (w >= 0) pend[w] = 1'b0;
    end

    idleCycles(LAT + 4);
    @(posedge clk);
    #1;
    checkOutput("drain_pending_returns", 128'(retq.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_port_arbiter.md
Name: load_port_arbiter

Overview:
- Shares one fixed-latency synchronous memory read port between NumReq load operators.
- Round-robin arbitration grants one requester per cycle and registers the read command to the memory.
- A tag pipeline tracks in-flight reads and steers returning data to the owning requester.
- Each requester gets a single-cycle valid plus a held copy of its last load result.
- Sits between the scheduled load operators of a datapath and a single-read-port RAM.

Parameters:
NumReq, 4, number of requesters (2..16)
AddrWidth, 16, read address width
DataWidth, 32, read data width
LoadLatency, 1, cycles from mem_rd asserted to mem_rdata valid (1..9)

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous, active-low reset
req  input  NumReq  per-requester load request; held high until granted
req_addr  input  NumReq*AddrWidth  packed addresses; requester i at bits [i*AddrWidth +: AddrWidth]
gnt  output  NumReq  one-hot grant, combinational, same cycle as req
mem_rd  output  1  registered read strobe to memory
mem_addr  output  AddrWidth  registered read address
mem_rdata  input  DataWidth  memory read data, valid LoadLatency cycles after mem_rd
rvalid  output  NumReq  one-cycle pulse when requester i's data is on ret
ret  output  NumReq*DataWidth  per-requester result; live data in the rvalid cycle, held value otherwise

Behaviour:
- Reset (async, rst_n low): mem_rd=0, mem_addr=0, rr_ptr=0, all tag-pipeline valids=0, all held ret registers=0. rvalid=0 while in reset. gnt is combinational from req and rr_ptr (rr_ptr=0 during reset).
- Arbitration:
  - Search starts at rr_ptr and wraps modulo NumReq. The first set req bit wins, and gnt has exactly that bit set.
  - If req==0, gnt=0.
  - On a grant to index k, rr_ptr <= (k+1) mod NumReq. With no grant, rr_ptr holds.
- Issue: at the edge ending grant cycle T, mem_rd <= |gnt and mem_addr <= addr of the winner. With no grant, mem_rd <= 0 and mem_addr holds.
- Throughput: one read per cycle, back-to-back permitted, with no bubbles between grants.
- Tag pipeline:
  - Stage 1 captures {valid=mem_rd, idx=winner index} in the same edge as mem_rd.
  - The tag shifts one stage per cycle and has LoadLatency stages beyond stage 1.
  - Stage LoadLatency+1 aligns with mem_rdata, cycle T+1+LoadLatency.
- Return:
  - In the cycle where the final tag is valid with idx=i: rvalid[i]=1 and ret slice i = mem_rdata combinationally. The held register i is loaded with mem_rdata at the end of that cycle.
  - Otherwise ret slice i = held register i.
  - At most one rvalid bit is high per cycle.
- Latency: req granted in cycle T → rvalid at cycle T+1+LoadLatency.
- Simultaneous events:
  - A return and a new grant for the same requester in one cycle are independent.
  - A requester may have up to LoadLatency+1 reads in flight. Results return in issue order.
- No backpressure on the return path. The requester must accept rvalid.
- A req deasserted before grant is dropped silently. req_addr must stay stable while req is high.
- Reset mid-operation: all in-flight tags are discarded and no rvalid is produced for them. Memory data arriving after reset deasserts is ignored.
- Index width: $clog2(NumReq). rr_ptr and the modulo wrap use this width.

Decomposition:
- Shared package: LOAD_LAT_MAX=9, clog2-based index width function, and the flattened-slice helper width constants.
- One sub-module, rr_arbiter (NumReq): req, rr_ptr in; gnt, winner index, any_gnt out; combinational.
- The pointer register, command registers, tag pipeline and return steering stay in the top level.

Test Plan:
1. Single request, LoadLatency=1: req[2]=1, addr=0x0010 at T.
   - gnt=4'b0100 at T; mem_rd=1, mem_addr=0x0010 at T+1.
   - Memory returns 0xDEADBEEF at T+2 → rvalid=4'b0100 at T+2, ret[2]=0xDEADBEEF from T+2 onward.
2. All four req high for 8 cycles from reset:
   - Grant order 0,1,2,3,0,1,2,3 with mem_rd high every cycle.
   - rvalid order matches, each 1+LoadLatency cycles after its grant.
3. LoadLatency=4: requester 1 granted three consecutive cycles, addrs 0x1,0x2,0x3, memory returns addr+0x100.
   - rvalid[1] at T+5,T+6,T+7 with ret[1]=0x101,0x102,0x103.
   - ret[1] holds 0x103 afterward.
4. Fairness: req=4'b1001 continuously after requester 0 was last granted → grants alternate 3,0,3,0.
5. Reset mid-flight, LoadLatency=3: assert rst_n=0 one cycle after two grants.
   - Outputs go 0 immediately; after release, no rvalid is produced for the discarded reads.
   - rr_ptr restarts at 0.
6. Idle: req=0 for 10 cycles → gnt=0, mem_rd=0, and mem_addr and all ret values unchanged.
